bpsk_demod: RTL and testbench

//  Coherent BPSK receiver: mixes incoming offset-binary ADC samples with the local cosine carrier

---
 rtl/bpsk_pkg.sv | 20 ++
 rtl/bpsk_mac.sv | 51 +++++
 rtl/bpsk_demod.sv | 106 ++++++++++
 tb/tb_bpsk_demod.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/bpsk_pkg.sv
// Shared definitions for the coherent BPSK demodulator: offset-binary helpers
// and the symbol FSM state encoding.
package bpsk_pkg;

   localparam int OFFSET_BIN_MID = 127;
   // Widest sample the conversion helper accepts; callers size-cast into it.
   localparam int OB_MAX_W       = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DUMP = 2'd2
   } state_t;

   // Offset-binary to two's complement: one extra bit so 0..2^W-1 maps around midscale.
   function automatic logic signed [OB_MAX_W:0] ob2s(input logic [OB_MAX_W-1:0] x);
      return $signed({1'b0, x}) - $signed((OB_MAX_W+1)'(OFFSET_BIN_MID));
   endfunction

endpackage

// File: rtl/bpsk_mac.sv
// Front half of the demodulator pipeline: offset removal (S1) and signed
// sample*carrier product (S2); valid and symbol-align flags travel with the data.
module bpsk_mac
   import bpsk_pkg::*;
#(
   parameter int DW = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [DW-1:0]          sample_in,
   input  logic [DW-1:0]          carrier_in,
   input  logic                   sample_valid,
   input  logic                   sym_align,
   output logic signed [2*DW+1:0] prod,
   output logic                   prod_valid,
   output logic                   prod_align
);

   logic signed [OB_MAX_W:0] s_full;
   logic signed [OB_MAX_W:0] c_full;
   logic signed [DW:0]       s1_s;
   logic signed [DW:0]       s1_c;
   logic                     s1_valid;
   logic                     s1_align;

   assign s_full = ob2s(OB_MAX_W'(sample_in));
   assign c_full = ob2s(OB_MAX_W'(carrier_in));

   // Dropping en clears the in-flight valids so a flushed sample never reaches the accumulator.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_s       <= '0;
         s1_c       <= '0;
         s1_valid   <= 1'b0;
         s1_align   <= 1'b0;
         prod       <= '0;
         prod_valid <= 1'b0;
         prod_align <= 1'b0;
      end else begin
         s1_s       <= s_full[DW:0];
         s1_c       <= c_full[DW:0];
         s1_valid   <= en & sample_valid;
         s1_align   <= en & sample_valid & sym_align;
         prod       <= (2*DW+2)'(s1_s) * (2*DW+2)'(s1_c);
         prod_valid <= en & s1_valid;
         prod_align <= en & s1_align;
      end
   end

endmodule

// File: rtl/bpsk_demod.sv
// Coherent BPSK receiver: integrates sample*carrier over SPS valid samples and
// emits one hard decision plus the raw correlation per symbol.
module bpsk_demod
   import bpsk_pkg::*;
#(
   parameter int SPS   = 100,
   parameter int DW    = 8,
   parameter int ACC_W = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic [DW-1:0]           sample_in,
   input  logic                    sample_valid,
   input  logic [DW-1:0]           carrier_in,
   input  logic                    sym_align,
   output logic                    bit_out,
   output logic                    bit_valid,
   output logic signed [ACC_W-1:0] corr_out,
   output state_t                  fsm_state
);

   localparam int              CNT_W    = 16;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SPS - 1);

   logic signed [2*DW+1:0]  prod;
   logic                    prod_valid;
   logic                    prod_align;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] p_ext;
   logic signed [ACC_W-1:0] acc_sum;
   logic [CNT_W-1:0]        sym_cnt;
   logic                    sym_end;
   state_t                  state;
   state_t                  state_nxt;

   bpsk_mac #(.DW(DW)) u_mac (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .sample_in    (sample_in),
      .carrier_in   (carrier_in),
      .sample_valid (sample_valid),
      .sym_align    (sym_align),
      .prod         (prod),
      .prod_valid   (prod_valid),
      .prod_align   (prod_align)
   );

   assign p_ext     = ACC_W'(prod);
   assign acc_sum   = acc + p_ext;
   // An aligned product always starts a symbol, even if it lands on the closing count.
   assign sym_end   = prod_valid & ~prod_align & (sym_cnt == LAST_CNT);
   assign fsm_state = state;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (!en) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    state_nxt = ACC;
            ACC:     if (sym_end) state_nxt = DUMP;
            DUMP:    state_nxt = ACC;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // DUMP is only the strobe cycle; accumulation of the next symbol never stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc       <= '0;
         sym_cnt   <= '0;
         bit_out   <= 1'b0;
         bit_valid <= 1'b0;
         corr_out  <= '0;
      end else begin
         bit_valid <= 1'b0;
         if (!en) begin
            acc     <= '0;
            sym_cnt <= '0;
         end else if (prod_valid) begin
            if (prod_align) begin
               acc     <= p_ext;
               sym_cnt <= CNT_W'(1);
            end else if (sym_end) begin
               corr_out  <= acc_sum;
               bit_out   <= ~acc_sum[ACC_W-1] & (acc_sum != '0);
               bit_valid <= 1'b1;
               acc       <= '0;
               sym_cnt   <= '0;
            end else begin
               acc     <= acc_sum;
               sym_cnt <= sym_cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_bpsk_demod.sv
// Scoreboard bench for bpsk_demod at SPS=8: directed symbols with hand-computed
// correlations, a decoupled monitor checking value, decision and strobe cycle.
module tb_bpsk_demod;
   import bpsk_pkg::*;

   localparam int SPS       = 8;
   localparam int DW        = 8;
   localparam int ACC_W     = 32;
   // sum((c-127)^2) over the cosine LUT below: 2*16129 + 4*8100
   localparam int LUT_CORR  = 64658;
   localparam int FULL_NEG  = -129032;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              en = 1'b0;
   logic [DW-1:0]     sample_in = '0;
   logic              sample_valid = 1'b0;
   logic [DW-1:0]     carrier_in = '0;
   logic              sym_align = 1'b0;
   logic              bit_out;
   logic              bit_valid;
   logic signed [ACC_W-1:0] corr_out;
   state_t            fsm_state;

   int                n_checks = 0;
   int                n_fail = 0;
   logic [31:0]       cyc = '0;
   // {expected strobe cycle, expected bit, expected correlation}
   logic [64:0]       exp_q[$];
   int                lut[8] = '{254, 217, 127, 37, 0, 37, 127, 217};

   bpsk_demod #(.SPS(SPS), .DW(DW), .ACC_W(ACC_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .carrier_in   (carrier_in),
      .sym_align    (sym_align),
      .bit_out      (bit_out),
      .bit_valid    (bit_valid),
      .corr_out     (corr_out),
      .fsm_state    (fsm_state)
   );

   // clock/reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 32'd1;

   task automatic check(input string name, input longint act, input longint req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // driver: called at a negedge, returns at the next negedge
   task automatic drive(input int s, input int c, input bit v, input bit a,
                        input bit last, input int exp_corr);
      sample_in    = DW'(s);
      carrier_in   = DW'(c);
      sample_valid = v;
      sym_align    = a;
      @(negedge clk);
      sample_valid = 1'b0;
      sym_align    = 1'b0;
      if (last) exp_q.push_back({cyc + 32'd2, exp_corr > 0, 32'(exp_corr)});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 1'b0, 1'b0, 1'b0, 0);
   endtask

   // mode 0: s=c, 1: s=254-c, 2: s=127, 3: s=254 c=0
   task automatic send_symbol(input int mode, input bit gaps, input int exp_corr);
      int s;
      int c;
      for (int i = 0; i < SPS; i++) begin
         c = lut[i];
         case (mode)
            0:       s = c;
            1:       s = 254 - c;
            2:       s = 127;
            default: begin s = 254; c = 0; end
         endcase
         drive(s, c, 1'b1, 1'b0, i == SPS - 1, exp_corr);
         if (gaps && i < SPS - 1) idle(1);
      end
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      logic [64:0] e;
      if (bit_valid) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_strobe: got bit_valid=1 corr=%0d, expected no strobe (cycle %0d)",
                     corr_out, cyc);
         end else begin
            e = exp_q.pop_front();
            check("corr_out", longint'(corr_out), longint'($signed(e[31:0])));
            check("bit_out", longint'(bit_out), longint'(e[32]));
            check("strobe_cycle", longint'(cyc), longint'(e[64:33]));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      check("reset_bit_out", longint'(bit_out), 0);
      check("reset_bit_valid", longint'(bit_valid), 0);
      check("reset_corr_out", longint'(corr_out), 0);
      check("reset_state", longint'(fsm_state), longint'(IDLE));
      rst = 1'b0;
      en  = 1'b1;
      idle(2);

      // matched carrier, back-to-back symbols
      send_symbol(0, 1'b0, LUT_CORR);
      send_symbol(0, 1'b0, LUT_CORR);
      send_symbol(0, 1'b0, LUT_CORR);
      // inverted signal
      send_symbol(1, 1'b0, -LUT_CORR);
      send_symbol(1, 1'b0, -LUT_CORR);
      // zero signal decides 0
      send_symbol(2, 1'b0, 0);
      // full-scale negative
      send_symbol(3, 1'b0, FULL_NEG);
      idle(4);
      // valid on alternate cycles
      send_symbol(0, 1'b1, LUT_CORR);
      idle(4);

      // 3 partial samples discarded by an aligned restart
      for (int i = 0; i < 3; i++) drive(254, 0, 1'b1, 1'b0, 1'b0, 0);
      for (int i = 0; i < SPS; i++)
         drive(lut[i], lut[i], 1'b1, i == 0, i == SPS - 1, LUT_CORR);
      idle(4);

      // en dropped at sample 5: flush, outputs hold
      for (int i = 0; i < 4; i++) drive(254, 0, 1'b1, 1'b0, 1'b0, 0);
      en = 1'b0;
      drive(254, 0, 1'b1, 1'b0, 1'b0, 0);
      idle(4);
      check("hold_corr_out", longint'(corr_out), LUT_CORR);
      check("hold_bit_out", longint'(bit_out), 1);
      check("disable_state", longint'(fsm_state), longint'(IDLE));
      en = 1'b1;
      idle(1);
      send_symbol(0, 1'b0, LUT_CORR);
      idle(4);

      // reset at sample 5: outputs back to reset values
      for (int i = 0; i < 4; i++) drive(254, 0, 1'b1, 1'b0, 1'b0, 0);
      rst = 1'b1;
      drive(254, 0, 1'b1, 1'b0, 1'b0, 0);
      idle(1);
      check("midrst_corr_out", longint'(corr_out), 0);
      check("midrst_bit_out", longint'(bit_out), 0);
      rst = 1'b0;
      idle(2);
      send_symbol(1, 1'b0, -LUT_CORR);

      idle(10);
      check("pending_expected", longint'(exp_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
